// File: rtl/time_bcd_decoder_if.sv
// time_bcd_decoder_if
//   Request/response bundle for the MM:SS BCD-to-binary converter.
//   master : time-entry side, drives start/bcd_in, observes results.
//   slave  : converter side, accepts start/bcd_in, drives results.
//   start   - request conversion of bcd_in (honoured only when idle)
//   bcd_in  - {min tens, min ones, sec tens, sec ones}, 4 bits each
//   minutes - binary minutes of last successful conversion
//   seconds - binary seconds of last successful conversion
//   busy    - conversion in progress
//   valid   - one-cycle pulse, minutes/seconds just updated
//   error   - one-cycle pulse, captured word rejected
interface time_bcd_decoder_if;
    logic        start;
    logic [15:0] bcd_in;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        busy;
    logic        valid;
    logic        error;

    modport master (
        output start, bcd_in,
        input  minutes, seconds, busy, valid, error
    );

    modport slave (
        input  start, bcd_in,
        output minutes, seconds, busy, valid, error
    );
endinterface

// File: rtl/time_bcd_decoder.sv
// time_bcd_decoder
//   Validates a four-digit MM:SS BCD word and converts both fields to
//   binary with a reverse double-dabble engine (shift right, then subtract
//   3 from any digit >= 8). Minutes and seconds are converted in parallel.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - slave side of time_bcd_decoder_if (start/bcd_in in,
//             minutes/seconds/busy/valid/error out)
module time_bcd_decoder (
    input  logic                 clk,
    input  logic                 rst_n,
    time_bcd_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  bcd_min_q, bcd_sec_q;
    logic [6:0]  bin_min_q, bin_sec_q;
    logic [2:0]  cnt_q;
    logic [5:0]  minutes_q, seconds_q;
    logic        valid_q, error_q;

    // One reverse double-dabble step on {bcd[7:0], bin[6:0]}: the BCD LSB
    // drops into bin[6], then each digit that now reads >= 8 is corrected.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] s;
        s = v >> 1;
        if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
        if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
        return s;
    endfunction

    logic [14:0] min_d, sec_d;
    logic        bad_d;

    assign min_d = dd_step({bcd_min_q, bin_min_q});
    assign sec_d = dd_step({bcd_sec_q, bin_sec_q});

    // Tens digits of a clock field stop at 5; ones digits at 9.
    assign bad_d = (bcd_min_q[7:4] > 4'd5) || (bcd_min_q[3:0] > 4'd9) ||
                   (bcd_sec_q[7:4] > 4'd5) || (bcd_sec_q[3:0] > 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_min_q <= '0;
            bcd_sec_q <= '0;
            bin_min_q <= '0;
            bin_sec_q <= '0;
            cnt_q     <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bcd_min_q <= bus.bcd_in[15:8];
                        bcd_sec_q <= bus.bcd_in[7:0];
                        bin_min_q <= '0;
                        bin_sec_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_d) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_min_q, bin_min_q} <= min_d;
                    {bcd_sec_q, bin_sec_q} <= sec_d;
                    cnt_q <= cnt_q + 3'd1;
                    // Seventh shift: take the freshly shifted value directly,
                    // bin[6] is always zero for fields up to 59.
                    if (cnt_q == 3'd6) begin
                        minutes_q <= min_d[5:0];
                        seconds_q <= sec_d[5:0];
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.valid   = valid_q;
    assign bus.error   = error_q;

endmodule

// File: tb/tb_time_bcd_decoder.sv
module tb_time_bcd_decoder;

    logic clk;
    logic rst_n;

    time_bcd_decoder_if bus ();

    time_bcd_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit   err;
        int   m;
        int   s;
        int   due;   // cycle count at which the pulse must be visible
        int   lat;   // busy cycles preceding the pulse
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   rst_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   last_m = 0;
    int   last_s = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    // Reference model: decimal reading of the four digits.
    function automatic exp_t ref_conv(input logic [15:0] w, input int c);
        exp_t e;
        int d3, d2, d1, d0;
        d3 = int'(w[15:12]); d2 = int'(w[11:8]);
        d1 = int'(w[7:4]);   d0 = int'(w[3:0]);
        e.err = !(d3 <= 5 && d2 <= 9 && d1 <= 5 && d0 <= 9);
        e.m   = d3 * 10 + d2;
        e.s   = d1 * 10 + d0;
        e.due = e.err ? c + 2 : c + 9;
        e.lat = e.err ? 1 : 8;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_busy;
        if (!rst_seen) begin
            q.delete();
            last_m = 0;
            last_s = 0;
            chk("reset_outputs",
                {26'd0, bus.minutes, bus.seconds, bus.busy, bus.valid, bus.error}, 0);
        end else begin
            exp_busy = (q.size() > 0) && (cyc >= q[0].due - q[0].lat) && (cyc < q[0].due);
            chk("busy", int'(bus.busy), int'(exp_busy));
            if (bus.valid || bus.error) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, bus.valid, bus.error}, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.due);
                    chk("error_flag", int'(bus.error), int'(e.err));
                    chk("valid_flag", int'(bus.valid), int'(!e.err));
                    if (!e.err) begin
                        last_m = e.m;
                        last_s = e.s;
                    end
                    chk("minutes", int'(bus.minutes), last_m);
                    chk("seconds", int'(bus.seconds), last_s);
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                chk("pulse_timeout", cyc, q[0].due - 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [15:0] w);
        bus.start  = 1'b1;
        bus.bcd_in = w;
        q.push_back(ref_conv(w, cyc));
        step();
        bus.start  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() > 0; i++) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1234;
        step();
        step();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        step();

        issue(16'h0000); wait_idle();
        issue(16'h5959); wait_idle();
        issue(16'h1207); wait_idle();
        issue(16'h5959); wait_idle();
        issue(16'h0A00); wait_idle();
        issue(16'h0060); wait_idle();
        issue(16'h6000); wait_idle();
        issue(16'h000F); wait_idle();

        // Starts while busy are ignored; a start in the valid cycle is taken.
        begin
            int c0;
            c0 = cyc;
            issue(16'h3045);
            while (cyc < c0 + 3) step();
            bus.start = 1'b1; bus.bcd_in = 16'h1111; step(); bus.start = 1'b0;
            while (cyc < c0 + 7) step();
            bus.start = 1'b1; bus.bcd_in = 16'h2222; step(); bus.start = 1'b0;
            while (cyc < c0 + 9) step();
            issue(16'h0001);
            wait_idle();
        end

        // Reset at k+5 aborts the conversion.
        begin
            int c0;
            c0 = cyc;
            issue(16'h4518);
            while (cyc < c0 + 5) step();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
            step();
            issue(16'h2233);
            wait_idle();
        end

        // Random words, mostly legal digits with occasional out-of-range ones.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            w = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10)),
                 4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            if ($urandom_range(0, 9) == 0) w = 16'($urandom);
            issue(w);
            wait_idle();
        end

        // Every legal MM:SS word with start held high: one result per 9 cycles.
        bus.start = 1'b1;
        for (int mm = 0; mm < 60; mm++) begin
            for (int ss = 0; ss < 60; ss++) begin
                logic [15:0] w;
                w = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
                bus.bcd_in = w;
                q.push_back(ref_conv(w, cyc));
                repeat (9) step();
            end
        end
        bus.start = 1'b0;
        wait_idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks done", checks);
        $fatal(1);
    end

endmodule
